// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: parity modes, serialiser and
// word-FSM state encodings, and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic parityBit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART frame serialiser: start bit, 8 data bits LSB first,
// optional parity bit and one or two stop bits, each CLK_DIV clocks long.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       byte_done,
  output logic       uarttx
);

  localparam bit             PAR_EN    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam int             STOPS     = (STOP_BITS == 2) ? 2 : 1;
  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_EARLY = CW'(CLK_DIV - 2);
  localparam logic [2:0]     STOP_LAST = 3'(STOPS - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_tx;
  logic          w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  // A start request overrides the final stop-bit cycle so bytes chain with no gap.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else if (start) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= byte_in;
      r_par   <= parityBit(byte_in, PARITY);
      r_tx    <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PAR_EN) begin
                r_state <= S_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          S_PAR: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
          S_STOP: begin
            if (r_bit == STOP_LAST) begin
              r_state <= S_IDLE;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Fires one cycle before the frame ends so the word FSM can react with registered outputs.
  assign byte_done = (r_state == S_STOP) && (r_bit == STOP_LAST) && (r_cnt == CNT_EARLY);
  assign uarttx    = r_tx;

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: captures a NUM_BYTES word on request and sends
// it as back-to-back frames through uart_byte_tx, then pulses tx_done.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int NUM_BYTES = 2,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   tx_req,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   uarttx
);

  localparam int         W        = 8 * NUM_BYTES;
  localparam logic [2:0] IDX_LAST = 3'(NUM_BYTES - 1);

  logic [1:0]   r_state;
  logic [W-1:0] r_word;
  logic [2:0]   r_index;
  logic         r_launch;
  logic [7:0]   w_byte;
  logic [W-1:0] w_wordNext;
  logic         w_byteDone;

  // The byte to send next always sits at the front of the shift register.
  assign w_byte     = (MSB_FIRST != 0) ? r_word[W-1 -: 8] : r_word[7:0];
  assign w_wordNext = (MSB_FIRST != 0) ? (r_word << 8) : (r_word >> 8);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_word   <= '0;
      r_index  <= '0;
      r_launch <= 1'b0;
    end else begin
      r_launch <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_req) begin
            r_state  <= SEND;
            r_word   <= tx_data;
            r_index  <= '0;
            r_launch <= 1'b1;
          end
        end
        SEND: begin
          if (r_launch) begin
            r_word <= w_wordNext;
          end
          if (w_byteDone) begin
            if (r_index == IDX_LAST) begin
              r_state <= DONE;
            end else begin
              r_index  <= r_index + 3'd1;
              r_launch <= 1'b1;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_busy = (r_state != IDLE);
  assign tx_done = (r_state == DONE);

  uart_byte_tx #(
    .CLK_DIV  (CLK_DIV),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_byte (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .start    (r_launch),
    .byte_in  (w_byte),
    .byte_done(w_byteDone),
    .uarttx   (uarttx)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: logs the serial line cycle by cycle after each
// acceptance edge (cycle 0) and checks frames, timing, parity and reset behaviour.
module tb_uart_word_tx;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic        req0, reqP, req3;
  logic [15:0] data0;
  logic [7:0]  dataP;
  logic [23:0] data3;
  logic        busy0, done0, line0;
  logic        busyE, doneE, lineE;
  logic        busyO, doneO, lineO;
  logic        busy3, done3, line3;

  int   sel;
  logic selLine, selDone, selBusy;
  logic lineLog [0:299];
  logic doneLog [0:299];
  logic busyLog [0:299];
  int   checks;
  int   failures;

  uart_word_tx #(.CLK_DIV(D), .NUM_BYTES(2), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)) dut0 (
    .sys_clk(clk), .rst(rst), .tx_req(req0), .tx_data(data0),
    .tx_busy(busy0), .tx_done(done0), .uarttx(line0));

  uart_word_tx #(.CLK_DIV(D), .NUM_BYTES(1), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(1)) dutE (
    .sys_clk(clk), .rst(rst), .tx_req(reqP), .tx_data(dataP),
    .tx_busy(busyE), .tx_done(doneE), .uarttx(lineE));

  uart_word_tx #(.CLK_DIV(D), .NUM_BYTES(1), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(1)) dutO (
    .sys_clk(clk), .rst(rst), .tx_req(reqP), .tx_data(dataP),
    .tx_busy(busyO), .tx_done(doneO), .uarttx(lineO));

  uart_word_tx #(.CLK_DIV(D), .NUM_BYTES(3), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(0)) dut3 (
    .sys_clk(clk), .rst(rst), .tx_req(req3), .tx_data(data3),
    .tx_busy(busy3), .tx_done(done3), .uarttx(line3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    selLine = line0;
    selDone = done0;
    selBusy = busy0;
    case (sel)
      1: begin selLine = lineE; selDone = doneE; selBusy = busyE; end
      2: begin selLine = lineO; selDone = doneO; selBusy = busyO; end
      3: begin selLine = line3; selDone = done3; selBusy = busy3; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raises the request of the selected DUT and steps through the acceptance edge.
  task automatic applyStimulus(input int which, input logic [23:0] word, input bit hold);
    sel = which;
    case (which)
      0:       begin data0 = word[15:0]; req0 = 1'b1; end
      1, 2:    begin dataP = word[7:0];  reqP = 1'b1; end
      default: begin data3 = word;       req3 = 1'b1; end
    endcase
    tick();
    if (!hold) begin
      req0 = 1'b0;
      reqP = 1'b0;
      req3 = 1'b0;
    end
  endtask

  task automatic captureCycles(input int n, input bit incOnDone, input bit poke, input bit rstPulse);
    for (int k = 1; k <= n; k++) begin
      tick();
      lineLog[k] = selLine;
      doneLog[k] = selDone;
      busyLog[k] = selBusy;
      if (incOnDone && selDone) data0 = data0 + 16'd1;
      if (incOnDone && k == 200) req0 = 1'b0;
      if (poke && k == 10) begin req0 = 1'b1; data0 = 16'hFFFF; end
      if (poke && k == 11) req0 = 1'b0;
      if (rstPulse && k == 50) rst = 1'b1;
      if (rstPulse && k == 51) rst = 1'b0;
    end
  endtask

  function automatic logic [7:0] decodeByte(input int startCycle);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = lineLog[startCycle + (i + 1) * D + D / 2];
    return b;
  endfunction

  function automatic logic expLine(input logic [7:0] b, input int par, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && par != 0) return (par == 2) ? (^b) : ~(^b);
    return 1'b1;
  endfunction

  function automatic int frameErrs(input int startCycle, input logic [7:0] b, input int par, input int stops);
    int bits;
    int errs;
    bits = 9 + ((par != 0) ? 1 : 0) + stops;
    errs = 0;
    for (int k = 0; k < bits * D; k++)
      if (lineLog[startCycle + k] !== expLine(b, par, k / D)) errs++;
    return errs;
  endfunction

  function automatic int countDone(input int first, input int last);
    int c;
    c = 0;
    for (int k = first; k <= last; k++) if (doneLog[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    sel = 0;
    rst = 1'b1;
    req0 = 1'b0; reqP = 1'b0; req3 = 1'b0;
    data0 = '0; dataP = '0; data3 = '0;

    repeat (3) tick();
    checkOutput("reset_line", line0, 1'b1);
    checkOutput("reset_busy", busy0, 1'b0);
    checkOutput("reset_done", done0, 1'b0);
    checkOutput("reset_line3", line3, 1'b1);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] single word 0x1234, MSB first");
    applyStimulus(0, 24'h001234, 1'b0);
    checkOutput("c0_busy", busy0, 1'b1);
    checkOutput("c0_line", line0, 1'b1);
    captureCycles(84, 1'b0, 1'b0, 1'b0);
    checkOutput("start_fall_c1", lineLog[1], 1'b0);
    checkOutput("byte0", decodeByte(1), 8'h12);
    checkOutput("byte1", decodeByte(41), 8'h34);
    checkOutput("frame0_cycles", frameErrs(1, 8'h12, 0, 1), 0);
    checkOutput("frame1_cycles", frameErrs(41, 8'h34, 0, 1), 0);
    checkOutput("done_c79", doneLog[79], 1'b0);
    checkOutput("done_c80", doneLog[80], 1'b1);
    checkOutput("done_count", countDone(1, 84), 1);
    checkOutput("line_c80", lineLog[80], 1'b1);
    checkOutput("busy_c80", busyLog[80], 1'b1);
    checkOutput("busy_c81", busyLog[81], 1'b0);
    checkOutput("line_c81", lineLog[81], 1'b1);

    $display("[TB] sustained request, data bumped on each done");
    applyStimulus(0, 24'h001234, 1'b1);
    captureCycles(250, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      int base;
      base = 82 * w;
      checkOutput($sformatf("sus_word%0d", w), {16'h0, decodeByte(base + 1), decodeByte(base + 41)},
                  32'h1234 + w);
      checkOutput($sformatf("sus_done%0d", w), doneLog[base + 80], 1'b1);
      if (w < 2) begin
        checkOutput($sformatf("sus_gap%0d", w), {lineLog[base + 81], lineLog[base + 82]}, 2'b11);
        checkOutput($sformatf("sus_start%0d", w), lineLog[base + 83], 1'b0);
      end
    end
    checkOutput("sus_done_count", countDone(1, 250), 3);
    checkOutput("sus_idle_after", busyLog[246], 1'b0);
    repeat (5) tick();

    $display("[TB] mid-word request and data change");
    applyStimulus(0, 24'h00C35A, 1'b0);
    captureCycles(100, 1'b0, 1'b1, 1'b0);
    checkOutput("ign_word", {decodeByte(1), decodeByte(41)}, 16'hC35A);
    checkOutput("ign_done_c80", doneLog[80], 1'b1);
    checkOutput("ign_done_count", countDone(1, 100), 1);
    checkOutput("ign_busy_c95", busyLog[95], 1'b0);

    $display("[TB] reset during second byte");
    applyStimulus(0, 24'h001234, 1'b0);
    captureCycles(100, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_line_c50", lineLog[50], 1'b0);
    checkOutput("rst_line_c51", lineLog[51], 1'b1);
    checkOutput("rst_busy_c51", busyLog[51], 1'b0);
    checkOutput("rst_no_done", countDone(1, 100), 0);
    applyStimulus(0, 24'h005AA5, 1'b0);
    captureCycles(84, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_word", {decodeByte(1), decodeByte(41)}, 16'h5AA5);
    checkOutput("post_rst_done", doneLog[80], 1'b1);

    $display("[TB] parity even/odd on 0x12");
    applyStimulus(1, 24'h000012, 1'b0);
    captureCycles(50, 1'b0, 1'b0, 1'b0);
    checkOutput("even_byte", decodeByte(1), 8'h12);
    checkOutput("even_parbit", lineLog[1 + 9 * D + D / 2], 1'b0);
    checkOutput("even_frame", frameErrs(1, 8'h12, 2, 1), 0);
    checkOutput("even_done_c44", doneLog[44], 1'b1);
    checkOutput("even_busy_c45", busyLog[45], 1'b0);
    applyStimulus(2, 24'h000012, 1'b0);
    captureCycles(50, 1'b0, 1'b0, 1'b0);
    checkOutput("odd_parbit", lineLog[1 + 9 * D + D / 2], 1'b1);
    checkOutput("odd_frame", frameErrs(1, 8'h12, 1, 1), 0);
    checkOutput("odd_done_c44", doneLog[44], 1'b1);

    $display("[TB] three bytes LSB first, two stop bits");
    applyStimulus(3, 24'hA3DC56, 1'b0);
    captureCycles(140, 1'b0, 1'b0, 1'b0);
    checkOutput("b3_byte0", decodeByte(1), 8'h56);
    checkOutput("b3_byte1", decodeByte(45), 8'hDC);
    checkOutput("b3_byte2", decodeByte(89), 8'hA3);
    checkOutput("b3_frame0", frameErrs(1, 8'h56, 0, 2), 0);
    checkOutput("b3_frame1", frameErrs(45, 8'hDC, 0, 2), 0);
    checkOutput("b3_frame2", frameErrs(89, 8'hA3, 0, 2), 0);
    checkOutput("b3_stop2_c43", lineLog[43], 1'b1);
    checkOutput("b3_next_start_c45", lineLog[45], 1'b0);
    checkOutput("b3_done_c132", doneLog[132], 1'b1);
    checkOutput("b3_busy_c133", busyLog[133], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
